// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory copy master: default widths and FSM state encodings.
package dmem_pkg;

    localparam int AW_DEF = 16;
    localparam int DW_DEF = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/dmem_copy_master.sv
// Data-memory bus initiator that copies a block of words from one address range to another,
// one read followed by one write per word. Optional running checksum: DMEM_COPY_CHECKSUM_EN.
module dmem_copy_master
    import dmem_pkg::*;
#(
    parameter int AW = AW_DEF,
    parameter int DW = DW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [AW-1:0] src_addr,
    input  logic [AW-1:0] dst_addr,
    input  logic [AW-1:0] length,
    output logic          busy,
    output logic          done,
    output logic [AW-1:0] words_copied,
    output logic [AW-1:0] mem_address,
    output logic          mem_read,
    output logic          mem_write,
    output logic [DW-1:0] mem_writedata,
    input  logic [DW-1:0] mem_readdata
`ifdef DMEM_COPY_CHECKSUM_EN
    ,
    output logic [DW-1:0] checksum
`endif
);

    state_t        state;
    logic [AW-1:0] src_ptr;
    logic [AW-1:0] dst_ptr;
    logic [AW-1:0] remaining;
    logic [DW-1:0] data_reg;
`ifdef DMEM_COPY_CHECKSUM_EN
    logic [DW-1:0] sum_reg;
`endif

    // Pointers, count and data word are don't-care outside an active copy, so only
    // control state and the visible counters are reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            words_copied <= '0;
`ifdef DMEM_COPY_CHECKSUM_EN
            sum_reg      <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        src_ptr      <= src_addr;
                        dst_ptr      <= dst_addr;
                        remaining    <= length;
                        words_copied <= '0;
`ifdef DMEM_COPY_CHECKSUM_EN
                        sum_reg      <= '0;
`endif
                        state        <= (length != '0) ? READ : DONE;
                    end
                end
                READ: begin
                    data_reg <= mem_readdata;
`ifdef DMEM_COPY_CHECKSUM_EN
                    sum_reg  <= sum_reg + mem_readdata;
`endif
                    state    <= WRITE;
                end
                WRITE: begin
                    src_ptr      <= src_ptr + AW'(1);
                    dst_ptr      <= dst_ptr + AW'(1);
                    remaining    <= remaining - AW'(1);
                    words_copied <= words_copied + AW'(1);
                    // remaining still holds the pre-decrement count here
                    state        <= (remaining != AW'(1)) ? READ : DONE;
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Bus outputs are pure decodes of registered state, so they are glitch-free
    // and read/write can never overlap.
    assign busy          = (state == READ) || (state == WRITE);
    assign done          = (state == DONE);
    assign mem_read      = (state == READ);
    assign mem_write     = (state == WRITE);
    assign mem_address   = (state == READ)  ? src_ptr :
                           (state == WRITE) ? dst_ptr : '0;
    assign mem_writedata = (state == WRITE) ? data_reg : '0;

`ifdef DMEM_COPY_CHECKSUM_EN
    assign checksum = sum_reg;
`endif

endmodule

// File: tb/tb_dmem_copy_master.sv
// Self-checking bench for dmem_copy_master: table of directed copies plus hand-written
// reset-abort and checksum sequences against a 256-word model memory (mem[i]=i).
module tb_dmem_copy_master;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] src_addr, dst_addr, length;
    logic        busy, done, mem_read, mem_write;
    logic [15:0] words_copied, mem_address, mem_writedata, mem_readdata;
`ifdef DMEM_COPY_CHECKSUM_EN
    logic [15:0] checksum;
`endif

    dmem_copy_master dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .src_addr      (src_addr),
        .dst_addr      (dst_addr),
        .length        (length),
        .busy          (busy),
        .done          (done),
        .words_copied  (words_copied),
        .mem_address   (mem_address),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .mem_writedata (mem_writedata),
        .mem_readdata  (mem_readdata)
`ifdef DMEM_COPY_CHECKSUM_EN
        ,
        .checksum      (checksum)
`endif
    );

    always #5 clk = ~clk;

    // Model memory: combinational read, commit on negedge of a write cycle.
    logic [15:0] mem [256];
    logic        preload = 1'b1;
    always @(negedge clk) begin
        if (preload) begin
            for (int i = 0; i < 256; i++) mem[i] <= 16'(i);
        end else if (mem_write) begin
            mem[mem_address[7:0]] <= mem_writedata;
        end
    end
    assign mem_readdata = mem[mem_address[7:0]];

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    logic [15:0] rd_log [8];
    logic [15:0] wr_log [8];
    int          chk_at_done;

    // Starts a copy so that start is sampled at edge T; cycle k below is cycle T+k.
    task automatic run_copy(input logic [15:0] s, input logic [15:0] d, input logic [15:0] n,
                            input int pulse_cyc, output int done_cyc, output int done_cnt,
                            output int nrd, output int nwr, output int both);
        done_cyc = -1; done_cnt = 0; nrd = 0; nwr = 0; both = 0; chk_at_done = -1;
        src_addr = s; dst_addr = d; length = n; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int cyc = 1; cyc <= 60; cyc++) begin
            start = (cyc == pulse_cyc);
            if (mem_read && mem_write) both++;
            if (mem_read) begin
                if (nrd < 8) rd_log[nrd] = mem_address;
                nrd++;
            end
            if (mem_write) begin
                if (nwr < 8) wr_log[nwr] = mem_address;
                nwr++;
            end
            if (done) begin
                done_cnt++;
                if (done_cyc < 0) begin
                    done_cyc = cyc;
`ifdef DMEM_COPY_CHECKSUM_EN
                    chk_at_done = int'(checksum);
`endif
                end
            end
            if (done_cyc > 0 && cyc >= done_cyc + 3) break;
            @(posedge clk); #1;
        end
        start = 1'b0;
    endtask

    typedef struct {
        string       name;
        logic [15:0] src;
        logic [15:0] dst;
        logic [15:0] len;
        int          pulse_cyc;
        int          exp_done_cyc;
        int          exp_words;
    } vec_t;

    vec_t vecs [4];

    initial begin
        int dc, dn, nr, nw, bo;

        vecs[0] = '{"basic",   16'd19,     16'd100, 16'd2, 0, 5, 2};
        vecs[1] = '{"len0",    16'd7,      16'd70,  16'd0, 0, 1, 0};
        vecs[2] = '{"wrap",    16'hFFFE,   16'd50,  16'd3, 0, 7, 3};
        vecs[3] = '{"overlap", 16'd10,     16'd11,  16'd3, 2, 7, 3};

        rst = 1'b1; start = 1'b0; src_addr = '0; dst_addr = '0; length = '0;
        repeat (3) @(posedge clk);
        #1;
        preload = 1'b0;

        check("rst_busy",  int'(busy), 0);
        check("rst_done",  int'(done), 0);
        check("rst_words", int'(words_copied), 0);
        check("rst_addr",  int'(mem_address), 0);
        check("rst_rd",    int'(mem_read), 0);
        check("rst_wr",    int'(mem_write), 0);
        check("rst_wdata", int'(mem_writedata), 0);
`ifdef DMEM_COPY_CHECKSUM_EN
        check("rst_checksum", int'(checksum), 0);
`endif
        rst = 1'b0;
        @(posedge clk); #1;

        for (int v = 0; v < 4; v++) begin
            run_copy(vecs[v].src, vecs[v].dst, vecs[v].len, vecs[v].pulse_cyc, dc, dn, nr, nw, bo);
            check({vecs[v].name, "_done_cyc"}, dc, vecs[v].exp_done_cyc);
            check({vecs[v].name, "_done_cnt"}, dn, 1);
            check({vecs[v].name, "_reads"},    nr, int'(vecs[v].len));
            check({vecs[v].name, "_writes"},   nw, int'(vecs[v].len));
            check({vecs[v].name, "_rw_both"},  bo, 0);
            check({vecs[v].name, "_words"},    int'(words_copied), vecs[v].exp_words);
            check({vecs[v].name, "_idle_busy"}, int'(busy), 0);
            for (int i = 0; i < int'(vecs[v].len) && i < 8; i++) begin
                check($sformatf("%s_rd_addr%0d", vecs[v].name, i), int'(rd_log[i]),
                      int'(16'(vecs[v].src + 16'(i))));
                check($sformatf("%s_wr_addr%0d", vecs[v].name, i), int'(wr_log[i]),
                      int'(16'(vecs[v].dst + 16'(i))));
            end
        end

        check("basic_mem100",   int'(mem[100]), 19);
        check("basic_mem101",   int'(mem[101]), 20);
        check("len0_mem70",     int'(mem[70]),  70);
        check("wrap_mem50",     int'(mem[50]),  254);
        check("wrap_mem51",     int'(mem[51]),  255);
        check("wrap_mem52",     int'(mem[52]),  0);
        check("overlap_mem11",  int'(mem[11]),  10);
        check("overlap_mem12",  int'(mem[12]),  10);
        check("overlap_mem13",  int'(mem[13]),  10);
        check("overlap_mem14",  int'(mem[14]),  14);

        // Reset during the second WRITE of a 4-word copy.
        src_addr = 16'd0; dst_addr = 16'd200; length = 16'd4; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
        end
        check("abort_in_write", int'(mem_write), 1);
        check("abort_wr_addr",  int'(mem_address), 201);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("abort_busy", int'(busy), 0);
        check("abort_addr", int'(mem_address), 0);
        begin
            int seen_done = 0, seen_acc = 0;
            for (int c = 0; c < 6; c++) begin
                if (done) seen_done++;
                if (mem_read || mem_write) seen_acc++;
                @(posedge clk); #1;
            end
            check("abort_no_done",   seen_done, 0);
            check("abort_no_access", seen_acc, 0);
        end
        check("abort_mem200", int'(mem[200]), 0);
        check("abort_mem201", int'(mem[201]), 1);
        check("abort_mem202", int'(mem[202]), 202);

`ifdef DMEM_COPY_CHECKSUM_EN
        run_copy(16'd1, 16'd60, 16'd4, 0, dc, dn, nr, nw, bo);
        check("cks_done_cyc", dc, 9);
        check("cks_at_done",  chk_at_done, 10);
        check("cks_held",     int'(checksum), 10);
        check("cks_mem63",    int'(mem[63]), 4);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
